// File: rtl/or_accum_lanes_pkg.sv
// Shared types and the bitwise operator helper for the or_accum_lanes block.
package or_accum_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2
  } op_e;

  // Widest operand the helper handles. Lanes zero-extend into this width
  // and keep only their low BITS bits of the result.
  localparam int MAX_BITS = 1024;

  // Bitwise combine of two operands with the selected operator.
  function automatic logic [MAX_BITS-1:0] apply_op(input op_e op,
                                                   input logic [MAX_BITS-1:0] a,
                                                   input logic [MAX_BITS-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

endpackage

// File: rtl/or_accum_lanes_if.sv
// Per-lane input and result handshake bundle for or_accum_lanes.
//
// Handshake: on both the input side (i_valid/i_ready) and the result side
// (c_valid/c_ready) a transfer happens on a rising clk edge where valid and
// ready are both 1 for that lane. A source holding valid=1 keeps its data
// stable until the transfer; ready may depend combinationally on valid's
// partner signals but valid never depends on ready.
interface or_accum_lanes_if #(
  parameter int NUM  = 4,
  parameter int BITS = 32
);
  logic [NUM-1:0]      i_valid;
  logic [NUM-1:0]      i_ready;
  logic [NUM*BITS-1:0] i_w;
  logic [NUM*BITS-1:0] i_r;
  logic [NUM-1:0]      c_valid;
  logic [NUM-1:0]      c_ready;
  logic [NUM*BITS-1:0] c;

  // Producer/collector side of the block.
  modport master (
    output i_valid, i_w, i_r, c_ready,
    input  i_ready, c_valid, c
  );

  // The accumulator itself.
  modport slave (
    input  i_valid, i_w, i_r, c_ready,
    output i_ready, c_valid, c
  );
endinterface

// File: rtl/or_accum_lanes_lane.sv
// One accumulation lane: combines w and r with the selected operator and
// folds BEATS accepted beats into a single registered result word.
module or_accum_lane
  import or_accum_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int OP    = 0,
  parameter int BEATS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [BITS-1:0] i_w,
  input  logic [BITS-1:0] i_r,
  output logic            c_valid,
  input  logic            c_ready,
  output logic [BITS-1:0] c
);

  localparam int            CW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST    = CW'(BEATS - 1);
  localparam logic [1:0]    OP_CODE = OP[1:0];
  localparam op_e           OP_SEL  = op_e'(OP_CODE);

  if (OP < 0 || OP > 2) begin : g_bad_op
    $error("or_accum_lane: OP must be 0 (OR), 1 (AND) or 2 (XOR)");
  end
  if (BITS < 1 || BITS > MAX_BITS) begin : g_bad_bits
    $error("or_accum_lane: BITS out of range");
  end
  if (BEATS < 1) begin : g_bad_beats
    $error("or_accum_lane: BEATS must be at least 1");
  end

  logic [CW-1:0]       cnt;
  logic [BITS-1:0]     acc;
  logic [BITS-1:0]     term;
  logic [BITS-1:0]     fold;
  logic                accept;
  logic                closing;
  logic [MAX_BITS-1:0] w_x, r_x, a_x, t_x, f_x;
  logic                unused_hi;

  // Operator on this beat, and the running value including this beat.
  always_comb begin
    w_x = '0;
    r_x = '0;
    a_x = '0;
    w_x[BITS-1:0] = i_w;
    r_x[BITS-1:0] = i_r;
    a_x[BITS-1:0] = acc;
    t_x  = apply_op(OP_SEL, w_x, r_x);
    f_x  = apply_op(OP_SEL, a_x, t_x);
    term = t_x[BITS-1:0];
    fold = (cnt == '0) ? term : f_x[BITS-1:0];
  end

  // Upper bits of the helper results are always zero-derived and dropped.
  assign unused_hi = ^{t_x, f_x};

  // Only the closing beat needs a free result slot; clear blocks all beats.
  assign i_ready = !clear && (!c_valid || c_ready || (cnt != LAST));
  assign accept  = i_valid && i_ready;
  assign closing = accept && (cnt == LAST);

  // Window state: beat counter and partial accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      acc <= fold;
      if (closing) cnt <= '0;
      else         cnt <= cnt + 1'b1;
    end
  end

  // Result register: a closing beat reloads it even while the old word is
  // being consumed, so back-to-back windows leave no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid <= 1'b0;
      c       <= '0;
    end else if (closing) begin
      c_valid <= 1'b1;
      c       <= fold;
    end else if (c_valid && c_ready) begin
      c_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/or_accum_lanes.sv
// NUM independent accumulation lanes; this level only slices the flat
// buses into per-lane operands and packs the per-lane results back.
module or_accum_lanes
  import or_accum_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int BITS  = 32,
  parameter int OP    = 0,
  parameter int BEATS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  or_accum_lanes_if.slave bus
);

  if (NUM < 1) begin : g_bad_num
    $error("or_accum_lanes: NUM must be at least 1");
  end

  logic            rdy_l [NUM];
  logic            cv_l  [NUM];
  logic [BITS-1:0] c_l   [NUM];

  for (genvar n = 0; n < NUM; n++) begin : g_lane
    or_accum_lane #(
      .BITS  (BITS),
      .OP    (OP),
      .BEATS (BEATS)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .i_valid (bus.i_valid[n]),
      .i_ready (rdy_l[n]),
      .i_w     (bus.i_w[n*BITS +: BITS]),
      .i_r     (bus.i_r[n*BITS +: BITS]),
      .c_valid (cv_l[n]),
      .c_ready (bus.c_ready[n]),
      .c       (c_l[n])
    );
  end

  // Pack per-lane handshake and result signals onto the flat bus.
  always_comb begin
    bus.i_ready = '0;
    bus.c_valid = '0;
    bus.c       = '0;
    for (int n = 0; n < NUM; n++) begin
      bus.i_ready[n]            = rdy_l[n];
      bus.c_valid[n]            = cv_l[n];
      bus.c[n*BITS +: BITS]     = c_l[n];
    end
  end

endmodule

// File: tb/tb_or_accum_lanes.sv
// Bench for or_accum_lanes: an OR/4-beat/4-lane instance carries most of
// the scenarios; AND/2-beat and XOR/1-beat single-lane instances cover the
// other operators.
module tb_or_accum_lanes;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- OR, NUM=4, BEATS=4 ----------------
  logic        v_a  [4];
  logic [31:0] w_a  [4];
  logic [31:0] r_a  [4];
  logic        cr_a [4];
  logic        clear;
  logic [31:0] exp_q [4][$];

  or_accum_lanes_if #(.NUM(4), .BITS(32)) bus_or ();
  assign bus_or.i_valid = {v_a[3], v_a[2], v_a[1], v_a[0]};
  assign bus_or.i_w     = {w_a[3], w_a[2], w_a[1], w_a[0]};
  assign bus_or.i_r     = {r_a[3], r_a[2], r_a[1], r_a[0]};
  assign bus_or.c_ready = {cr_a[3], cr_a[2], cr_a[1], cr_a[0]};

  or_accum_lanes #(.NUM(4), .BITS(32), .OP(0), .BEATS(4)) u_or (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus_or)
  );

  // ---------------- AND, NUM=1, BEATS=2 ----------------
  logic        av, acr, aclr;
  logic [31:0] aw, ar;
  logic [31:0] exp_and[$];

  or_accum_lanes_if #(.NUM(1), .BITS(32)) bus_and ();
  assign bus_and.i_valid = av;
  assign bus_and.i_w     = aw;
  assign bus_and.i_r     = ar;
  assign bus_and.c_ready = acr;

  or_accum_lanes #(.NUM(1), .BITS(32), .OP(1), .BEATS(2)) u_and (
    .clk(clk), .rst(rst), .clear(aclr), .bus(bus_and)
  );

  // ---------------- XOR, NUM=1, BEATS=1 ----------------
  logic        xv, xcr, xclr;
  logic [31:0] xw, xr;
  logic [31:0] exp_xor[$];

  or_accum_lanes_if #(.NUM(1), .BITS(32)) bus_xor ();
  assign bus_xor.i_valid = xv;
  assign bus_xor.i_w     = xw;
  assign bus_xor.i_r     = xr;
  assign bus_xor.c_ready = xcr;

  or_accum_lanes #(.NUM(1), .BITS(32), .OP(2), .BEATS(1)) u_xor (
    .clk(clk), .rst(rst), .clear(xclr), .bus(bus_xor)
  );

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Present one beat on an OR lane (called at posedge+1) and hold it until
  // it is accepted; returns at posedge+1 after the accepting edge.
  task automatic send(input int l, input logic [31:0] w, input logic [31:0] r);
    bit ok;
    ok     = 1'b0;
    v_a[l] = 1'b1;
    w_a[l] = w;
    r_a[l] = r;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ok = bus_or.i_ready[l];
      @(posedge clk);
      #1;
      if (ok) break;
    end
    v_a[l] = 1'b0;
    if (!ok) fail_now($sformatf("send_timeout_lane%0d", l), "i_ready stayed 0 for 200 cycles, required 1");
  endtask

  // Reference stimulus for the multi-lane run.
  function automatic logic [31:0] w_of(input int l, input int win, input int b);
    return (32'(l) << 28) | (32'h1 << (b + 4*win));
  endfunction

  function automatic logic [31:0] r_of(input int l, input int win, input int b);
    return 32'h1 << (16 + b + 4*win + l);
  endfunction

  function automatic logic [31:0] ref_win(input int l, input int win);
    logic [31:0] v;
    v = 32'h0;
    for (int b = 0; b < 4; b++) v = v | w_of(l, win, b) | r_of(l, win, b);
    return v;
  endfunction

  task automatic lane_run(input int l, input int gap);
    for (int win = 0; win < 3; win++) begin
      exp_q[l].push_back(ref_win(l, win));
      for (int b = 0; b < 4; b++) begin
        send(l, w_of(l, win, b), r_of(l, win, b));
        repeat (gap - 1) sync();
      end
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (bus_or.c_valid[l] && bus_or.c_ready[l]) begin
        if (exp_q[l].size() == 0)
          fail_now($sformatf("or_lane%0d_unexpected", l),
                   $sformatf("result %h with no expected word queued", bus_or.c[l*32 +: 32]));
        else
          check($sformatf("or_lane%0d_result", l), bus_or.c[l*32 +: 32], exp_q[l].pop_front());
      end
    end
    if (bus_and.c_valid[0] && bus_and.c_ready[0]) begin
      if (exp_and.size() == 0) fail_now("and_unexpected", $sformatf("result %h with nothing queued", bus_and.c));
      else check("and_result", bus_and.c, exp_and.pop_front());
    end
    if (bus_xor.c_valid[0] && bus_xor.c_ready[0]) begin
      if (exp_xor.size() == 0) fail_now("xor_unexpected", $sformatf("result %h with nothing queued", bus_xor.c));
      else check("xor_result", bus_xor.c, exp_xor.pop_front());
    end
  end

  // Guard against a hang anywhere in the sequence.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  bit mdone;

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; clear = 1'b0; mdone = 1'b0;
    for (int l = 0; l < 4; l++) begin
      v_a[l] = 1'b0; w_a[l] = '0; r_a[l] = '0; cr_a[l] = 1'b1;
    end
    av = 0; acr = 1; aclr = 0; aw = '0; ar = '0;
    xv = 0; xcr = 1; xclr = 0; xw = '0; xr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_c_valid", 32'(bus_or.c_valid), 32'h0);
    check("rst_c_zero", 32'(|bus_or.c), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 32'(bus_or.i_ready), 32'hF);

    // OR window, c_ready=1: 0x1|0x10|0x100|0x1000
    sync();
    exp_q[0].push_back(32'h0000_1111);
    send(0, 32'h1, 32'h0);
    send(0, 32'h0, 32'h10);
    send(0, 32'h100, 32'h0);
    @(negedge clk);
    check("t1_no_early_valid", 32'(bus_or.c_valid[0]), 32'h0);
    sync();
    send(0, 32'h0, 32'h1000);
    @(negedge clk);
    check("t1_valid_next_cycle", 32'(bus_or.c_valid[0]), 32'h1);
    @(negedge clk);
    check("t1_valid_one_cycle", 32'(bus_or.c_valid[0]), 32'h0);
    check("t1_c_held_after_consume", bus_or.c[31:0], 32'h0000_1111);

    // Backpressure: result A pending, beats 1..3 of B accepted, 4th held
    sync();
    cr_a[0] = 1'b0;
    exp_q[0].push_back(32'h0000_000F);
    send(0, 32'h1, 32'h0); send(0, 32'h2, 32'h0);
    send(0, 32'h4, 32'h0); send(0, 32'h8, 32'h0);
    exp_q[0].push_back(32'h0000_00F0);
    send(0, 32'h10, 32'h0); send(0, 32'h20, 32'h0); send(0, 32'h40, 32'h0);
    v_a[0] = 1'b1; w_a[0] = 32'h80; r_a[0] = 32'h0;
    repeat (3) begin
      @(negedge clk);
      check("bp_closing_beat_held", 32'(bus_or.i_ready[0]), 32'h0);
      check("bp_pending_c_stable", bus_or.c[31:0], 32'h0000_000F);
    end
    @(posedge clk); #1 cr_a[0] = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(bus_or.i_ready[0]), 32'h1);
    @(posedge clk); #1 v_a[0] = 1'b0;
    @(negedge clk);
    check("bp_c_valid_stays", 32'(bus_or.c_valid[0]), 32'h1);
    check("bp_new_c_loaded", bus_or.c[31:0], 32'h0000_00F0);
    @(negedge clk);
    check("bp_drained", 32'(bus_or.c_valid[0]), 32'h0);

    // clear after 2 of 4 beats, with a beat presented during clear
    sync();
    send(0, 32'h100, 32'h0);
    send(0, 32'h200, 32'h0);
    clear = 1'b1; v_a[0] = 1'b1; w_a[0] = 32'h8000;
    @(negedge clk);
    check("clr_blocks_ready", 32'(bus_or.i_ready), 32'h0);
    @(posedge clk); #1 clear = 1'b0; v_a[0] = 1'b0;
    exp_q[0].push_back(32'h0000_000F);
    send(0, 32'h1, 32'h0); send(0, 32'h2, 32'h0);
    send(0, 32'h4, 32'h0); send(0, 32'h8, 32'h0);
    repeat (2) @(negedge clk);

    // All four lanes at different rates with random c_ready
    sync();
    fork
      begin
        fork
          lane_run(0, 1);
          lane_run(1, 2);
          lane_run(2, 2);
          lane_run(3, 3);
        join
        mdone = 1'b1;
      end
      begin
        while (!mdone) begin
          @(posedge clk); #1;
          for (int l = 0; l < 4; l++) cr_a[l] = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #2;
    for (int l = 0; l < 4; l++) cr_a[l] = 1'b1;
    repeat (4) @(negedge clk);
    for (int l = 0; l < 4; l++)
      check($sformatf("multi_drain_lane%0d", l), 32'(exp_q[l].size()), 32'h0);

    // Async reset mid-window (lane 0) and with a pending result (lane 1)
    sync();
    cr_a[1] = 1'b0;
    send(0, 32'h1, 32'h0); send(0, 32'h2, 32'h0);
    send(1, 32'hA, 32'h0); send(1, 32'h0, 32'h5);
    send(1, 32'hA0, 32'h0); send(1, 32'h0, 32'h50);
    @(negedge clk);
    check("rst_pre_pending", 32'(bus_or.c_valid[1]), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_c_valid", 32'(bus_or.c_valid), 32'h0);
    check("rst_async_c_zero", 32'(|bus_or.c), 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    cr_a[1] = 1'b1;
    sync();
    exp_q[0].push_back(32'h0000_00F0);
    send(0, 32'h10, 32'h0); send(0, 32'h20, 32'h0);
    send(0, 32'h40, 32'h0); send(0, 32'h80, 32'h0);
    exp_q[1].push_back(32'h0000_0F00);
    send(1, 32'h100, 32'h0); send(1, 32'h200, 32'h0);
    send(1, 32'h400, 32'h0); send(1, 32'h800, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_recover_drain0", 32'(exp_q[0].size()), 32'h0);
    check("rst_recover_drain1", 32'(exp_q[1].size()), 32'h0);

    // AND, BEATS=2: (FFFF00FF & FF00FFFF) & (0F0F0F0F & FFFFFFFF) = 0F00000F
    sync();
    exp_and.push_back(32'h0F00_000F);
    exp_and.push_back(32'h1234_5678);
    av = 1'b1; aw = 32'hFFFF_00FF; ar = 32'hFF00_FFFF;
    @(negedge clk); check("and_rdy_b0", 32'(bus_and.i_ready), 32'h1);
    @(posedge clk); #1 aw = 32'h0F0F_0F0F; ar = 32'hFFFF_FFFF;
    @(negedge clk); check("and_rdy_b1", 32'(bus_and.i_ready), 32'h1);
    @(posedge clk); #1 aw = 32'hFFFF_FFFF; ar = 32'h1234_5678;
    @(negedge clk); check("and_valid_w0", 32'(bus_and.c_valid), 32'h1);
    @(posedge clk); #1 aw = 32'hFFFF_FFFF; ar = 32'hFFFF_FFFF;
    @(posedge clk); #1 av = 1'b0;
    @(negedge clk); check("and_valid_w1", 32'(bus_and.c_valid), 32'h1);
    @(negedge clk); check("and_idle", 32'(bus_and.c_valid), 32'h0);

    // XOR, BEATS=1: A5A5A5A5 ^ FFFF0000 = 5A5AA5A5 every cycle
    sync();
    for (int i = 0; i < 5; i++) exp_xor.push_back(32'h5A5A_A5A5);
    xv = 1'b1; xw = 32'hA5A5_A5A5; xr = 32'hFFFF_0000;
    sync();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("xor_no_gap", 32'(bus_xor.c_valid), 32'h1);
      sync();
      if (i == 3) xv = 1'b0;
    end
    @(negedge clk);
    check("xor_idle", 32'(bus_xor.c_valid), 32'h0);

    repeat (2) @(negedge clk);
    check("and_queue_empty", 32'(exp_and.size()), 32'h0);
    check("xor_queue_empty", 32'(exp_xor.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
